// File: rtl/single_cycle_mips_core.sv
// Single-cycle MIPS subset CPU: every instruction is fetched, decoded, executed and retired in one clock.
// Instruction and data memories are plain byte arrays preloaded by the surrounding environment.
module single_cycle_mips_core #(
  parameter int IMEM_BYTES = 1024,
  parameter int DMEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_out,
  output logic [31:0] inst,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic        zero
);

  localparam int IAW = $clog2(IMEM_BYTES);
  localparam int DAW = $clog2(DMEM_BYTES);

  logic [7:0]  imem [IMEM_BYTES];
  logic [7:0]  dmem [DMEM_BYTES];
  logic [31:0] regs_q [32];
  logic [31:0] pc_q, pc_d;

  logic [IAW-1:0] iaddr;
  logic [DAW-1:0] daddr;
  logic [4:0]     rs, rt, rd, wbDest;
  logic [31:0]    signImm, rsVal, rtVal, aluB, aluResult, memData, wbData;
  logic [31:0]    pcPlus4, branchTarget, jumpTarget;

  logic [2:0] aluopr;
  logic       regdst, alusrc, memtoreg, regwrite, memread, memwrite;
  logic       branch, pcsrc, adrtopc, regtopc, pctoreg, lastreg;

  // Little-endian fetch: the byte at PC lands in inst[7:0].
  assign iaddr  = pc_q[IAW-1:0];
  assign inst   = {imem[iaddr + IAW'(3)], imem[iaddr + IAW'(2)],
                   imem[iaddr + IAW'(1)], imem[iaddr]};
  assign pc_out = pc_q;
  assign opcode = inst[31:26];
  assign func   = inst[5:0];

  assign rs      = inst[25:21];
  assign rt      = inst[20:16];
  assign rd      = inst[15:11];
  assign signImm = {{16{inst[15]}}, inst[15:0]};

  assign rsVal = (rs == 5'd0) ? 32'd0 : regs_q[rs];
  assign rtVal = (rt == 5'd0) ? 32'd0 : regs_q[rt];

  always_comb begin
    aluopr   = 3'b010;
    regdst   = 1'b0;
    alusrc   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    branch   = 1'b0;
    adrtopc  = 1'b0;
    regtopc  = 1'b0;
    pctoreg  = 1'b0;
    lastreg  = 1'b0;
    case (opcode)
      6'b000000: begin
        case (func)
          6'b100000: begin aluopr = 3'b010; regdst = 1'b1; regwrite = 1'b1; end
          6'b100010: begin aluopr = 3'b110; regdst = 1'b1; regwrite = 1'b1; end
          6'b100100: begin aluopr = 3'b000; regdst = 1'b1; regwrite = 1'b1; end
          6'b100101: begin aluopr = 3'b001; regdst = 1'b1; regwrite = 1'b1; end
          6'b101010: begin aluopr = 3'b111; regdst = 1'b1; regwrite = 1'b1; end
          6'b001000: regtopc = 1'b1;
          default: ;
        endcase
      end
      6'b100011: begin alusrc = 1'b1; memtoreg = 1'b1; regwrite = 1'b1; memread = 1'b1; end
      6'b101011: begin alusrc = 1'b1; memwrite = 1'b1; end
      6'b000100: begin aluopr = 3'b110; branch = 1'b1; end
      6'b001000: begin alusrc = 1'b1; regwrite = 1'b1; end
      6'b001010: begin aluopr = 3'b111; alusrc = 1'b1; regwrite = 1'b1; end
      6'b000010: adrtopc = 1'b1;
      6'b000011: begin adrtopc = 1'b1; pctoreg = 1'b1; lastreg = 1'b1; regwrite = 1'b1; end
      default: ;
    endcase
  end

  assign aluB = alusrc ? signImm : rtVal;

  always_comb begin
    case (aluopr)
      3'b000:  aluResult = rsVal & aluB;
      3'b001:  aluResult = rsVal | aluB;
      3'b110:  aluResult = rsVal - aluB;
      3'b111:  aluResult = {31'd0, $signed(rsVal) < $signed(aluB)};
      default: aluResult = rsVal + aluB;
    endcase
  end

  assign zero  = (aluResult == 32'd0);
  // Branch decision kept outside the controller so the ALU-to-zero path does not loop through it.
  assign pcsrc = branch & zero;

  assign daddr   = aluResult[DAW-1:0];
  assign memData = memread ? {dmem[daddr + DAW'(3)], dmem[daddr + DAW'(2)],
                              dmem[daddr + DAW'(1)], dmem[daddr]} : 32'd0;

  assign pcPlus4      = pc_q + 32'd4;
  assign branchTarget = pcPlus4 + {signImm[29:0], 2'b00};
  assign jumpTarget   = {pcPlus4[31:28], inst[25:0], 2'b00};

  always_comb begin
    if (regtopc)      pc_d = rsVal;
    else if (adrtopc) pc_d = jumpTarget;
    else if (pcsrc)   pc_d = branchTarget;
    else              pc_d = pcPlus4;
  end

  assign wbData = pctoreg ? pcPlus4 : (memtoreg ? memData : aluResult);
  assign wbDest = lastreg ? 5'd31 : (regdst ? rd : rt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= 32'd0;
    else      pc_q <= pc_d;
  end

  // R0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else if (regwrite && (wbDest != 5'd0)) begin
      regs_q[wbDest] <= wbData;
    end
  end

  // Data memory keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (memwrite) begin
      dmem[daddr]            <= rtVal[7:0];
      dmem[daddr + DAW'(1)]  <= rtVal[15:8];
      dmem[daddr + DAW'(2)]  <= rtVal[23:16];
      dmem[daddr + DAW'(3)]  <= rtVal[31:24];
    end
  end

endmodule

// File: tb/tb_single_cycle_mips_core.sv
// Bench for single_cycle_mips_core: a directed program plus random programs, each compared
// cycle by cycle against an instruction-level interpreter of the MIPS subset.
module tb_single_cycle_mips_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_out, inst;
  logic [5:0]  opcode, func;
  logic        zero;

  int testsRun  = 0;
  int failCount = 0;

  logic [31:0] prog [256];
  logic [31:0] mRegs [32];
  logic [7:0]  mDmem [4096];
  logic [31:0] mPc;

  localparam logic [31:0] FILL = 32'hFC00_0000;

  single_cycle_mips_core dut (
    .clk    (clk),
    .rst    (rst),
    .pc_out (pc_out),
    .inst   (inst),
    .opcode (opcode),
    .func   (func),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] encR(input int rs, input int rt, input int rd, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] encI(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] encJ(input int op, input int wordIdx);
    return {6'(op), 26'(wordIdx)};
  endfunction

  // Interpreter: executes the instruction at mPc and reports what the zero flag should be beforehand.
  task automatic modelStep(output bit zValid, output logic [31:0] zExp);
    logic [31:0] ins, a, b, simm, r, nextPc, addr, val;
    int op, fn, rs, rt, rd;
    ins    = prog[mPc[9:2]];
    op     = int'(ins[31:26]);
    fn     = int'(ins[5:0]);
    rs     = int'(ins[25:21]);
    rt     = int'(ins[20:16]);
    rd     = int'(ins[15:11]);
    simm   = {{16{ins[15]}}, ins[15:0]};
    a      = mRegs[rs];
    b      = mRegs[rt];
    nextPc = mPc + 4;
    zValid = 1'b0;
    zExp   = 32'd0;
    r      = 32'd0;
    case (op)
      0: begin
        zValid = 1'b1;
        case (fn)
          32: r = a + b;
          34: r = a - b;
          36: r = a & b;
          37: r = a | b;
          42: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: zValid = 1'b0;
        endcase
        if (zValid && rd != 0) mRegs[rd] = r;
        if (fn == 8) nextPc = a;
      end
      35, 43: begin
        addr = a + simm;
        zValid = 1'b1;
        r = addr;
        if (op == 35) begin
          for (int k = 0; k < 4; k++) val[8*k +: 8] = mDmem[(int'(addr[11:0]) + k) % 4096];
          if (rt != 0) mRegs[rt] = val;
        end else begin
          for (int k = 0; k < 4; k++) mDmem[(int'(addr[11:0]) + k) % 4096] = b[8*k +: 8];
        end
      end
      4: begin
        zValid = 1'b1;
        r = a - b;
        if (a == b) nextPc = mPc + 4 + simm * 4;
      end
      8, 10: begin
        zValid = 1'b1;
        if (op == 8) r = a + simm;
        else         r = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0;
        if (rt != 0) mRegs[rt] = r;
      end
      2, 3: begin
        if (op == 3) mRegs[31] = mPc + 4;
        nextPc = {nextPc[31:28], ins[25:0], 2'b00};
      end
      default: ;
    endcase
    zExp = (r == 32'd0) ? 32'd1 : 32'd0;
    mPc  = nextPc;
  endtask

  task automatic buildDirected(output int n);
    for (int i = 0; i < 256; i++) prog[i] = FILL;
    prog[0]  = encI(8, 0, 1, 5);
    prog[1]  = encI(8, 0, 2, -3);
    prog[2]  = encR(1, 2, 3, 32);
    prog[3]  = encR(1, 2, 4, 34);
    prog[4]  = encR(2, 1, 5, 42);
    prog[5]  = encI(43, 0, 1, 2000);
    prog[6]  = encI(35, 0, 6, 2000);
    prog[7]  = encI(43, 0, 4, 2004);
    prog[8]  = encJ(3, 16);
    prog[9]  = encI(4, 1, 6, 2);
    prog[10] = encI(8, 0, 7, 1);
    prog[11] = encI(8, 0, 7, 2);
    prog[12] = encI(4, 1, 2, 5);
    prog[13] = encI(8, 0, 0, 7);
    prog[14] = encJ(2, 24);
    prog[16] = encI(8, 0, 8, 12);
    prog[17] = encI(8, 0, 9, 10);
    prog[18] = encR(8, 9, 10, 36);
    prog[19] = encR(8, 9, 11, 37);
    prog[20] = encR(31, 0, 0, 8);
    prog[24] = encI(10, 2, 12, -2);
    prog[25] = encR(1, 1, 13, 63);
    n = 26;
  endtask

  // Random programs only branch and jump forward, so each one always runs off its end.
  task automatic buildRandom(output int n);
    int fns [5] = '{32, 34, 36, 37, 42};
    int tgt;
    n = 48;
    for (int i = 0; i < 256; i++) prog[i] = FILL;
    for (int i = 0; i < 16; i++) prog[i] = encI(43, 0, 0, 2048 + 4 * i);
    for (int i = 16; i < n; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: prog[i] = encR($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                                fns[$urandom_range(0, 4)]);
        3:       prog[i] = encI(8, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535));
        4:       prog[i] = encI(10, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535));
        5:       prog[i] = encI(35, 0, $urandom_range(0, 7), 2048 + 4 * $urandom_range(0, 15));
        6:       prog[i] = encI(43, 0, $urandom_range(0, 7), 2048 + 4 * $urandom_range(0, 15));
        7:       prog[i] = encI(4, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        8: begin
          tgt = i + 1 + $urandom_range(0, 2);
          if (tgt > n) tgt = n;
          prog[i] = encJ($urandom_range(0, 1) ? 3 : 2, tgt);
        end
        default: prog[i] = $urandom_range(0, 1) ? encR(1, 2, 3, 63) : {6'b111110, 26'($urandom)};
      endcase
    end
  endtask

  task automatic applyStimulus(input int nWords);
    bit          zValid;
    logic [31:0] zExp;
    logic [31:0] expIns;
    int          steps;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("reset_pc", pc_out, 32'd0);
    for (int i = 0; i < 32; i++) checkOutput($sformatf("reset_reg%0d", i), dut.regs_q[i], 32'd0);
    mPc = 32'd0;
    for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
    for (int w = 0; w < 256; w++)
      for (int k = 0; k < 4; k++) dut.imem[4*w + k] = prog[w][8*k +: 8];
    @(negedge clk);
    rst = 1'b1;
    steps = 0;
    while (mPc < 32'(nWords * 4) && steps < 400) begin
      #1;
      expIns = prog[mPc[9:2]];
      checkOutput("pc", pc_out, mPc);
      checkOutput("inst", inst, expIns);
      checkOutput("opcode", {26'd0, opcode}, {26'd0, expIns[31:26]});
      checkOutput("func", {26'd0, func}, {26'd0, expIns[5:0]});
      modelStep(zValid, zExp);
      if (zValid) checkOutput("zero", {31'd0, zero}, zExp);
      @(posedge clk);
      @(negedge clk);
      steps++;
    end
    #1;
    checkOutput("end_pc", pc_out, mPc);
    checkOutput("end_opcode", {26'd0, opcode}, {26'd0, prog[mPc[9:2]][31:26]});
    for (int i = 0; i < 32; i++) checkOutput($sformatf("reg%0d", i), dut.regs_q[i], mRegs[i]);
    for (int a = 2000; a < 2008; a++) checkOutput($sformatf("mem%0d", a), {24'd0, dut.dmem[a]}, {24'd0, mDmem[a]});
    if (nWords == 48)
      for (int a = 2048; a < 2112; a++) checkOutput($sformatf("mem%0d", a), {24'd0, dut.dmem[a]}, {24'd0, mDmem[a]});
  endtask

  initial begin
    int n;
    rst = 1'b0;
    #3;
    buildDirected(n);
    applyStimulus(n);
    checkOutput("dir_R3", dut.regs_q[3], 32'd2);
    checkOutput("dir_R4", dut.regs_q[4], 32'd8);
    checkOutput("dir_R5", dut.regs_q[5], 32'd1);
    checkOutput("dir_R6", dut.regs_q[6], 32'd5);
    checkOutput("dir_R7_skipped", dut.regs_q[7], 32'd0);
    checkOutput("dir_R10_and", dut.regs_q[10], 32'h8);
    checkOutput("dir_R11_or", dut.regs_q[11], 32'hE);
    checkOutput("dir_R12_slti", dut.regs_q[12], 32'd1);
    checkOutput("dir_R31_link", dut.regs_q[31], 32'h24);
    checkOutput("dir_R0", dut.regs_q[0], 32'd0);
    checkOutput("dir_mem2000", {24'd0, dut.dmem[2000]}, 32'h05);
    checkOutput("dir_mem2001", {24'd0, dut.dmem[2001]}, 32'h00);
    checkOutput("dir_mem2004", {24'd0, dut.dmem[2004]}, 32'h08);
    for (int p = 0; p < 6; p++) begin
      buildRandom(n);
      applyStimulus(n);
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
